// File: rtl/multi_device_manager_pkg.sv
// Shared constants and address decode for the coprocessor channel manager.
package devmgr_pkg;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int unsigned CH_STRIDE  = 8;
  localparam int unsigned STATUS_OFS = 4;

  typedef struct packed {
    logic       hit;
    logic       is_status;
    logic [3:0] index;
  } dec_t;

  // ofs is the address relative to the window base; wrap-around below base misses.
  function automatic dec_t decode_channel(input logic [31:0] ofs, input int unsigned num_dev);
    dec_t d;
    d.hit       = ofs < 32'(num_dev * CH_STRIDE);
    d.is_status = (ofs & 32'(STATUS_OFS)) != 32'd0;
    d.index     = 4'(ofs / 32'(CH_STRIDE));
    return d;
  endfunction

endpackage

// File: rtl/multi_device_manager_if.sv
// Datapath load/store bus plus the data-memory side of the pass-through.
interface multi_device_manager_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addressIn;
  logic [DATA_W-1:0] dataIn;
  logic              writeIn;
  logic              readIn;
  logic [DATA_W-1:0] memOutIn;
  logic [DATA_W-1:0] memOutOut;
  logic              writeOut;
  logic              readOut;

  modport slave (
    input  addressIn, dataIn, writeIn, readIn, memOutIn,
    output memOutOut, writeOut, readOut
  );

  modport master (
    output addressIn, dataIn, writeIn, readIn, memOutIn,
    input  memOutOut, writeOut, readOut
  );
endinterface

// File: rtl/multi_device_manager_channel.sv
// One device channel: operand register, busy/done/err flags and one-cycle start pulse.
module devmgr_channel
  import devmgr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              store,
  input  logic              stat_rd,
  input  logic              err_clr,
  input  logic              finish,
  input  logic [DATA_W-1:0] wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] data
);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              fin_q, fin_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fin_ev, busy_eff, accept;

  always_comb begin
    // Only a rising finish retires the channel, so a held level is harmless.
    fin_ev   = finish & ~fin_q & busy_q;
    busy_eff = busy_q & ~fin_ev;
    accept   = store & ~busy_eff;
    fin_d    = finish;
    busy_d   = busy_eff | accept;
    start_d  = accept;
    data_d   = accept ? wdata : data_q;
    done_d   = fin_ev | (done_q & ~stat_rd);
    err_d    = (store & busy_eff) | (err_q & ~err_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      fin_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      fin_q   <= fin_d;
      data_q  <= data_d;
    end
  end

  assign start = start_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign data  = data_q;

endmodule

// File: rtl/multi_device_manager.sv
// Memory-mapped manager for NUM_DEV coprocessor channels between datapath and data memory.
// Define DEVMGR_IRQ_EN to add the irqMask register and the irq output.
module multi_device_manager
  import devmgr_pkg::*;
#(
  parameter int                NUM_DEV   = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic                      clock,
  input  logic                      reset,
  multi_device_manager_if.slave     bus,
  input  logic [NUM_DEV-1:0]        finish,
  output logic [NUM_DEV-1:0]        start,
  output logic [NUM_DEV*DATA_W-1:0] data
`ifdef DEVMGR_IRQ_EN
  ,
  output logic                      irq
`endif
);

  logic [ADDR_W-1:0]              ofs;
  logic [31:0]                    ofs32;
  dec_t                           dec;
  logic                           in_win;
  logic [NUM_DEV-1:0]             ch_busy, ch_done, ch_err;
  logic [NUM_DEV-1:0][DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]              rd_data;

  assign ofs   = bus.addressIn - BASE_ADDR;
  assign ofs32 = 32'(ofs);
  assign dec   = decode_channel(ofs32, NUM_DEV);

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_ch
    logic sel;
    assign sel = dec.hit && (dec.index == 4'(i));

    devmgr_channel #(.DATA_W(DATA_W)) u_ch (
      .clock   (clock),
      .reset   (reset),
      .store   (bus.writeIn & sel & ~dec.is_status),
      .stat_rd (bus.readIn & sel & dec.is_status),
      .err_clr (bus.writeIn & sel & dec.is_status & bus.dataIn[STAT_ERR]),
      .finish  (finish[i]),
      .wdata   (bus.dataIn),
      .start   (start[i]),
      .busy    (ch_busy[i]),
      .done    (ch_done[i]),
      .err     (ch_err[i]),
      .data    (ch_data[i])
    );
  end

  assign data = ch_data;

`ifdef DEVMGR_IRQ_EN
  logic               mask_hit;
  logic [NUM_DEV-1:0] mask_q, mask_d;
  logic               irq_q, irq_d;

  // Mask word sits directly after the last channel's status register.
  assign mask_hit = ofs32[31:2] == 30'(NUM_DEV * 2);
  assign in_win   = dec.hit | mask_hit;

  always_comb begin
    mask_d = (bus.writeIn && mask_hit) ? bus.dataIn[NUM_DEV-1:0] : mask_q;
    irq_d  = |(ch_done & mask_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign in_win = dec.hit;
`endif

  always_comb begin
    rd_data = bus.memOutIn;
    if (dec.hit) begin
      rd_data = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
        if (dec.index == 4'(i)) begin
          if (dec.is_status) begin
            rd_data[STAT_BUSY] = ch_busy[i];
            rd_data[STAT_DONE] = ch_done[i];
            rd_data[STAT_ERR]  = ch_err[i];
          end else begin
            rd_data = ch_data[i];
          end
        end
      end
    end
`ifdef DEVMGR_IRQ_EN
    if (mask_hit) begin
      rd_data                = '0;
      rd_data[NUM_DEV-1:0]   = mask_q;
    end
`endif
  end

  assign bus.memOutOut = rd_data;
  assign bus.readOut   = bus.readIn & ~in_win;
  assign bus.writeOut  = bus.writeIn & ~in_win;

endmodule

// File: tb/tb_multi_device_manager.sv
// Directed bench for multi_device_manager; irq scenario only when DEVMGR_IRQ_EN is defined.
module tb_multi_device_manager;

  localparam int          NUM_DEV = 4;
  localparam int          DATA_W  = 32;
  localparam logic [31:0] BASE    = 32'h0000_FF00;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_DEV-1:0]        finish;
  logic [NUM_DEV-1:0]        start;
  logic [NUM_DEV*DATA_W-1:0] data;
`ifdef DEVMGR_IRQ_EN
  logic                      irq;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_device_manager_if #(.DATA_W(DATA_W), .ADDR_W(32)) bus ();

  multi_device_manager #(
    .NUM_DEV(NUM_DEV), .DATA_W(DATA_W), .ADDR_W(32), .BASE_ADDR(BASE)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .finish (finish),
    .start  (start),
    .data   (data)
`ifdef DEVMGR_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.addressIn = '0;
    bus.dataIn    = '0;
    bus.writeIn   = 1'b0;
    bus.readIn    = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.addressIn = a;
    bus.dataIn    = d;
    bus.writeIn   = 1'b1;
    bus.readIn    = 1'b0;
    cyc();
    bus.writeIn   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    finish = '0;
    bus.memOutIn = '0;
    idle_bus();
    cyc();
    cyc();
    reset = 1'b0;
    total_cnt++;
    if (start !== 4'b0000) $display("FAIL reset_start got=%h exp=0", start); else pass_cnt++;
    total_cnt++;
    if (data !== '0) $display("FAIL reset_data got=%h exp=0", data); else pass_cnt++;
    for (int i = 0; i < NUM_DEV; i++) begin
      bus.addressIn = BASE + 32'(8 * i + 4);
      bus.readIn = 1'b1;
      #1;
      total_cnt++;
      if (bus.memOutOut !== 32'h0) $display("FAIL reset_status ch%0d got=%h exp=0", i, bus.memOutOut);
      else pass_cnt++;
      cyc();
    end
    idle_bus();
  endtask

  task automatic test_passthrough();
    bus.addressIn = 32'h5;
    bus.readIn = 1'b1;
    bus.writeIn = 1'b0;
    bus.memOutIn = 32'h3;
    #1;
    total_cnt++;
    if (bus.readOut !== 1'b1 || bus.writeOut !== 1'b0 || bus.memOutOut !== 32'h3)
      $display("FAIL pass_read got=%b/%b/%h exp=1/0/3", bus.readOut, bus.writeOut, bus.memOutOut);
    else pass_cnt++;
    bus.readIn = 1'b0;
    bus.writeIn = 1'b1;
    bus.dataIn = 32'h77;
    #1;
    total_cnt++;
    if (bus.readOut !== 1'b0 || bus.writeOut !== 1'b1)
      $display("FAIL pass_write got=%b/%b exp=0/1", bus.readOut, bus.writeOut);
    else pass_cnt++;
    cyc();
    bus.writeIn = 1'b0;
    total_cnt++;
    if (start !== 4'b0000) $display("FAIL pass_start got=%h exp=0", start); else pass_cnt++;
    bus.addressIn = BASE - 32'd4;
    bus.readIn = 1'b1;
    bus.memOutIn = 32'h1234;
    #1;
    total_cnt++;
    if (bus.readOut !== 1'b1 || bus.memOutOut !== 32'h1234)
      $display("FAIL pass_below got=%b/%h exp=1/1234", bus.readOut, bus.memOutOut);
    else pass_cnt++;
`ifndef DEVMGR_IRQ_EN
    bus.addressIn = BASE + 32'(8 * NUM_DEV);
    #1;
    total_cnt++;
    if (bus.readOut !== 1'b1 || bus.memOutOut !== 32'h1234)
      $display("FAIL pass_above got=%b/%h exp=1/1234", bus.readOut, bus.memOutOut);
    else pass_cnt++;
`endif
    idle_bus();
    bus.memOutIn = 32'hDEAD_BEEF;
  endtask

  task automatic test_launch();
    do_store(BASE, 32'h3);
    total_cnt++;
    if (start !== 4'b0001) $display("FAIL launch_start got=%h exp=1", start); else pass_cnt++;
    total_cnt++;
    if (data[31:0] !== 32'h3) $display("FAIL launch_data got=%h exp=3", data[31:0]); else pass_cnt++;
    cyc();
    total_cnt++;
    if (start !== 4'b0000) $display("FAIL launch_pulse_width got=%h exp=0", start); else pass_cnt++;
    bus.addressIn = BASE + 32'd4;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h1 || bus.readOut !== 1'b0 || bus.writeOut !== 1'b0)
      $display("FAIL launch_status got=%h rd=%b exp=1 rd=0", bus.memOutOut, bus.readOut);
    else pass_cnt++;
    bus.addressIn = BASE;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h3) $display("FAIL launch_dataload got=%h exp=3", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
  endtask

  task automatic test_busy_drop();
    do_store(BASE, 32'h7);
    total_cnt++;
    if (start !== 4'b0000) $display("FAIL drop_start got=%h exp=0", start); else pass_cnt++;
    total_cnt++;
    if (data[31:0] !== 32'h3) $display("FAIL drop_data got=%h exp=3", data[31:0]); else pass_cnt++;
    bus.addressIn = BASE + 32'd4;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h5) $display("FAIL drop_status got=%h exp=5", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
    do_store(BASE + 32'd4, 32'h4);
    bus.addressIn = BASE + 32'd4;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h1) $display("FAIL errclr_status got=%h exp=1", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
  endtask

  task automatic test_finish();
    finish[0] = 1'b1;
    cyc();
    finish[0] = 1'b0;
    bus.addressIn = BASE + 32'd4;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h2) $display("FAIL finish_status got=%h exp=2", bus.memOutOut); else pass_cnt++;
    cyc();
    total_cnt++;
    if (bus.memOutOut !== 32'h0) $display("FAIL finish_clr_on_read got=%h exp=0", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
  endtask

  task automatic test_simultaneous();
    do_store(BASE + 32'd16, 32'h1);
    total_cnt++;
    if (start !== 4'b0100) $display("FAIL simul_first_start got=%h exp=4", start); else pass_cnt++;
    finish[2] = 1'b1;
    do_store(BASE + 32'd16, 32'hA);
    finish[2] = 1'b0;
    total_cnt++;
    if (start !== 4'b0100) $display("FAIL simul_restart got=%h exp=4", start); else pass_cnt++;
    total_cnt++;
    if (data[95:64] !== 32'hA) $display("FAIL simul_data got=%h exp=a", data[95:64]); else pass_cnt++;
    bus.addressIn = BASE + 32'd20;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h3) $display("FAIL simul_status got=%h exp=3", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
  endtask

  task automatic test_read_write_both();
    bus.addressIn = BASE + 32'd24;
    bus.dataIn = 32'h9;
    bus.readIn = 1'b1;
    bus.writeIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h0 || bus.readOut !== 1'b0 || bus.writeOut !== 1'b0)
      $display("FAIL rw_pre got=%h/%b/%b exp=0/0/0", bus.memOutOut, bus.readOut, bus.writeOut);
    else pass_cnt++;
    cyc();
    idle_bus();
    total_cnt++;
    if (start !== 4'b1000 || data[127:96] !== 32'h9)
      $display("FAIL rw_store got=%h/%h exp=8/9", start, data[127:96]);
    else pass_cnt++;
  endtask

  task automatic test_idle_finish();
    finish[1] = 1'b1;
    cyc();
    finish[1] = 1'b0;
    cyc();
    bus.addressIn = BASE + 32'd12;
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h0) $display("FAIL idle_finish got=%h exp=0", bus.memOutOut); else pass_cnt++;
    cyc();
    idle_bus();
  endtask

`ifdef DEVMGR_IRQ_EN
  task automatic test_irq();
    do_store(BASE + 32'(8 * NUM_DEV), 32'h2);
    bus.addressIn = BASE + 32'(8 * NUM_DEV);
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (bus.memOutOut !== 32'h2 || bus.readOut !== 1'b0)
      $display("FAIL irq_mask_read got=%h/%b exp=2/0", bus.memOutOut, bus.readOut);
    else pass_cnt++;
    idle_bus();
    do_store(BASE + 32'd8, 32'h55);
    finish[1] = 1'b1;
    cyc();
    finish[1] = 1'b0;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_early got=%b exp=0", irq); else pass_cnt++;
    cyc();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_assert got=%b exp=1", irq); else pass_cnt++;
    bus.addressIn = BASE + 32'd12;
    bus.readIn = 1'b1;
    cyc();
    idle_bus();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_hold got=%b exp=1", irq); else pass_cnt++;
    cyc();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_drop got=%b exp=0", irq); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    do_store(BASE, 32'h11);
    reset = 1'b1;
    finish[0] = 1'b1;
    bus.addressIn = BASE + 32'd8;
    bus.dataIn = 32'h22;
    bus.writeIn = 1'b1;
    cyc();
    total_cnt++;
    if (start !== 4'b0000) $display("FAIL rstmid_start0 got=%h exp=0", start); else pass_cnt++;
    reset = 1'b0;
    finish = '0;
    idle_bus();
    cyc();
    total_cnt++;
    if (start !== 4'b0000 || data !== '0) $display("FAIL rstmid_start1 got=%h/%h exp=0/0", start, data);
    else pass_cnt++;
    for (int i = 0; i < NUM_DEV; i++) begin
      bus.addressIn = BASE + 32'(8 * i + 4);
      bus.readIn = 1'b1;
      #1;
      total_cnt++;
      if (bus.memOutOut !== 32'h0) $display("FAIL rstmid_status ch%0d got=%h exp=0", i, bus.memOutOut);
      else pass_cnt++;
      cyc();
    end
    idle_bus();
`ifdef DEVMGR_IRQ_EN
    bus.addressIn = BASE + 32'(8 * NUM_DEV);
    bus.readIn = 1'b1;
    #1;
    total_cnt++;
    if (irq !== 1'b0 || bus.memOutOut !== 32'h0)
      $display("FAIL rstmid_irq got=%b/%h exp=0/0", irq, bus.memOutOut);
    else pass_cnt++;
    idle_bus();
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_launch();
    test_busy_drop();
    test_finish();
    test_simultaneous();
    test_read_write_both();
    test_idle_finish();
`ifdef DEVMGR_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
